idma_inoc_ibuffer_noc_reader: RTL and testbench
===============================================

# idma_inoc_ibuffer_noc_reader

Downstream consumer of the ibuffer NoC read port. After the DMA fill phase completes, it streams a contiguous range of ibuffer words onto the NoC transmit interface. It issues ready-gated read requests, tracks outstanding reads with credits, buffers returned data in a small FIFO, and presents it as a valid/ready stream with a last marker.

## Interface
- DATA_WIDTH, 128: ibuffer word / NoC flit width
- MEM_AW, 15: ibuffer word address width
- FIFO_DEPTH, 4: return-data FIFO entries (power of two, ≥2); also the credit limit
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; latches base_addr/len when idle
- base_addr  in  MEM_AW  first word address
- len  in  MEM_AW+1  word count; 0 = empty transfer
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses (inclusive)
- done  out  1  one-cycle pulse when the transfer completes
- mem_cen  out  1  read request valid
- mem_wen  out  1  constant 0 (read only)
- mem_ready  in  1  request accepted when mem_cen & mem_ready
- mem_addr  out  MEM_AW  request address
- mem_rdata  in  DATA_WIDTH  read data
- mem_rvalid  in  1  read data valid
- mem_rready  out  1  read data accept
- noc_tx_valid  out  1  flit valid
- noc_tx_ready  in  1  flit accept
- noc_tx_data  out  DATA_WIDTH  flit payload
- noc_tx_last  out  1  marks final flit of the transfer

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start with len≠0: latch addr=base_addr, req_left=len, flit_left=len; go to ISSUE.
  - start with len=0: done pulses next cycle; no memory or NoC activity; stay in IDLE.
- ISSUE:
  - mem_cen = (req_left≠0) & (outstanding + fifo_count < FIFO_DEPTH).
  - On each request handshake: addr increments modulo 2^MEM_AW (wraps to 0 after all-ones); req_left decrements; outstanding increments.
  - When the last request handshakes, go to DRAIN.
- DRAIN: stay until flit_left reaches 0 on a NoC handshake; then pulse done and return to IDLE.
- mem_rready = (state≠IDLE) & FIFO not full. The credit rule guarantees it is never deasserted while rvalid is high. A bench assertion checks this.
- On each return handshake: push mem_rdata into the FIFO; outstanding decrements. Returns are in request order.
- Same-cycle request and return: outstanding is unchanged.
- NoC side:
  - noc_tx_valid = FIFO not empty; noc_tx_data = FIFO head.
  - noc_tx_last = noc_tx_valid & (flit_left==1).
  - On each NoC handshake: pop the FIFO; flit_left decrements.
- start while busy is ignored; latched parameters are not disturbed.
- mem_rvalid in IDLE is ignored; no push occurs.
- Reset mid-transfer: all state clears immediately to IDLE. Counters and FIFO pointers clear, no done pulse. Read data still in flight after reset release is dropped because rready=0 in IDLE.

## Timing
- All outputs are 0 during and after reset: busy, done, mem_cen, mem_wen, mem_addr, mem_rready, noc_tx_valid, noc_tx_data, noc_tx_last.
- First mem_cen is asserted the cycle after start is accepted.
- Each return handshake in cycle N produces noc_tx_valid in cycle N+1. The FIFO has registered output with no combinational rdata→tx path.
- With mem_ready=1, a 1-cycle memory rvalid latency, and noc_tx_ready=1, throughput is one word per cycle sustained.
- done asserts the cycle after the final NoC handshake. A new start is accepted in the cycle done is high; done and start may coincide.
- Counters are MEM_AW+1 bits wide. outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits wide.

## Test plan
- base_addr=0x10, len=8, mem_ready=1, rvalid 1 cycle after request, tx_ready=1:
  - 8 requests to 0x10–0x17 on consecutive cycles.
  - 8 flits in order; last on the 8th; done 1 cycle after it.
  - busy high for exactly the transfer span.
- len=0:
  - done pulses the cycle after start.
  - mem_cen and noc_tx_valid stay 0.
- base_addr=0x7FFE, len=4: requests go to 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- noc_tx_ready held 0 after start, len=16, FIFO_DEPTH=4:
  - Exactly 4 requests are issued, then mem_cen holds 0.
  - Releasing tx_ready drains all 16 flits in order with no loss.
  - mem_rready never falls while rvalid=1.
- Random mem_ready / rvalid delay (0–5 cycles) and random tx_ready, len=100: 100 flits match memory contents in order; one last; one done.
- Apply rst_n low mid-transfer, then a new start with len=3:
  - All outputs drop to 0; no done.
  - The new transfer completes with exactly 3 flits.
  - A second start issued while busy is ignored.

Source files
------------

// File: rtl/idma_inoc_ibuffer_noc_reader.sv
// Streams a contiguous ibuffer word range onto the NoC transmit port.
// Ports: start/base_addr/len/busy/done control, mem_* read port, noc_tx_* stream.
`timescale 1ns/1ps
module idma_inoc_ibuffer_noc_reader #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AW     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MEM_AW-1:0]     base_addr,
  input  logic [MEM_AW:0]       len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_cen,
  output logic                  mem_wen,
  input  logic                  mem_ready,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  output logic                  noc_tx_valid,
  input  logic                  noc_tx_ready,
  output logic [DATA_WIDTH-1:0] noc_tx_data,
  output logic                  noc_tx_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic [MEM_AW-1:0]     addr;
  logic [MEM_AW:0]       req_left;
  logic [MEM_AW:0]       flit_left;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         fifo_count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic [CW:0] in_use;
  logic        fifo_full;
  logic        req_fire;
  logic        ret_fire;
  logic        tx_fire;

  // Reads in flight plus words held must fit the FIFO, so every
  // returned word always has a slot waiting for it.
  assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign fifo_full = fifo_count == CW'(FIFO_DEPTH);

  assign mem_cen = (state == ISSUE)
                 & (req_left != '0)
                 & (in_use < (CW+1)'(FIFO_DEPTH));
  assign mem_wen    = 1'b0;
  assign mem_addr   = addr;
  assign mem_rready = (state != IDLE) & ~fifo_full;

  assign noc_tx_valid = fifo_count != '0;
  assign noc_tx_data  = noc_tx_valid ? fifo_mem[rd_ptr] : '0;
  assign noc_tx_last  = noc_tx_valid
                      & (flit_left == (MEM_AW+1)'(1));

  assign busy = (state != IDLE) | done_q;
  assign done = done_q;

  assign req_fire = mem_cen & mem_ready;
  assign ret_fire = mem_rvalid & mem_rready;
  assign tx_fire  = noc_tx_valid & noc_tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      req_left  <= '0;
      flit_left <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              addr      <= base_addr;
              req_left  <= len;
              flit_left <= len;
              state     <= ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (req_fire) begin
            addr     <= addr + 1'b1;
            req_left <= req_left - 1'b1;
            if (req_left == (MEM_AW+1)'(1))
              state <= DRAIN;
          end
          if (tx_fire)
            flit_left <= flit_left - 1'b1;
        end
        DRAIN: begin
          if (tx_fire) begin
            flit_left <= flit_left - 1'b1;
            if (flit_left == (MEM_AW+1)'(1)) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, ret_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (ret_fire)
        wr_ptr <= wr_ptr + 1'b1;
      if (tx_fire)
        rd_ptr <= rd_ptr + 1'b1;
      case ({ret_fire, tx_fire})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ret_fire)
      fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_idma_inoc_ibuffer_noc_reader.sv
// Bench for idma_inoc_ibuffer_noc_reader: vector table plus hand sequences,
// with a queue-based memory responder and expected-flit model.
`timescale 1ns/1ps
module tb_idma_inoc_ibuffer_noc_reader;

  localparam int DW = 128;
  localparam int AW = 15;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done;
  logic          mem_cen, mem_wen;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic          mem_rready;
  logic          noc_tx_valid;
  logic          noc_tx_ready = 1'b0;
  logic [DW-1:0] noc_tx_data;
  logic          noc_tx_last;

  idma_inoc_ibuffer_noc_reader #(
    .DATA_WIDTH(DW), .MEM_AW(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done),
    .mem_cen(mem_cen), .mem_wen(mem_wen),
    .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_rready(mem_rready),
    .noc_tx_valid(noc_tx_valid), .noc_tx_ready(noc_tx_ready),
    .noc_tx_data(noc_tx_data), .noc_tx_last(noc_tx_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  function automatic void chk(string name, logic [127:0] act,
                              logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [DW-1:0] memfn(logic [AW-1:0] a);
    return {8{a, 1'b1}} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  typedef struct {
    logic [AW-1:0] a;
    int            due;
  } rsp_t;

  rsp_t          rsp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  int cyc = 0;
  int mem_mode = 0;
  int tx_mode = 0;
  bit flush = 1'b0;

  int nreq, nflit, nlast, ndone, busy_cnt;
  int first_req_cyc, last_req_cyc, done_cyc, start_cyc;
  logic [AW-1:0] last_req_addr;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory responder, NoC sink and checker
  initial forever begin
    @(posedge clk);
    #1;
    if (flush) begin
      rsp_q.delete();
      flush = 1'b0;
    end
    mem_ready = (mem_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    case (tx_mode)
      0:       noc_tx_ready = 1'b1;
      1:       noc_tx_ready = 1'b0;
      default: noc_tx_ready = ($urandom_range(0, 1) == 1);
    endcase
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memfn(rsp_q[0].a);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    if (rst_n) begin
      if (mem_cen && mem_ready) begin
        nreq++;
        if (nreq == 1) first_req_cyc = cyc;
        last_req_cyc  = cyc;
        last_req_addr = mem_addr;
        if (exp_addr_q.size() == 0) begin
          checks++;
          $display("FAIL req_extra: got request to %0h expected none",
                   mem_addr);
        end else begin
          chk("req_addr", mem_addr, exp_addr_q.pop_front());
        end
        rsp_q.push_back('{mem_addr, cyc + 1 +
          ((mem_mode != 0) ? int'($urandom_range(0, 5)) : 0)});
      end
      if (mem_rvalid && busy)
        chk("rready_held", mem_rready, 1);
      if (mem_rvalid && mem_rready)
        void'(rsp_q.pop_front());
      if (noc_tx_valid && noc_tx_ready) begin
        nflit++;
        if (noc_tx_last) nlast++;
        if (exp_data_q.size() == 0) begin
          checks++;
          $display("FAIL flit_extra: got flit %0h expected none",
                   noc_tx_data);
        end else begin
          chk("flit_last", noc_tx_last, exp_data_q.size() == 1);
          chk("flit_data", noc_tx_data, exp_data_q.pop_front());
        end
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l,
                          input bit accept);
    @(posedge clk);
    #1;
    if (accept) begin
      nreq = 0; nflit = 0; nlast = 0; ndone = 0; busy_cnt = 0;
      first_req_cyc = -1; last_req_cyc = -1; done_cyc = -1;
      start_cyc = cyc;
      for (int i = 0; i < int'(l); i++) begin
        exp_addr_q.push_back(b + AW'(i));
        exp_data_q.push_back(memfn(b + AW'(i)));
      end
    end
    start = 1'b1;
    base_addr = b;
    len = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    len = (AW+1)'($urandom);
  endtask

  task automatic wait_done(input int bound, input string name);
    int n = 0;
    while (ndone == 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, ndone != 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctl"},
        {busy, done, mem_cen, mem_wen, mem_rready,
         noc_tx_valid, noc_tx_last}, 0);
    chk({name, "_addr"}, mem_addr, 0);
    chk({name, "_data"}, noc_tx_data, 0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mmode;
    int            tmode;
    int            exp_req;
    logic [AW-1:0] exp_last_addr;
    int            exp_busy;
    int            exp_done_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{15'h0010, 16'd8,   0, 0, 8,   15'h0017, 11, 11};
    vecs[1] = '{15'h0123, 16'd0,   0, 0, 0,   15'h0000, 1,  1};
    vecs[2] = '{15'h7FFE, 16'd4,   0, 0, 4,   15'h0001, 7,  7};
    vecs[3] = '{15'h1234, 16'd100, 1, 2, 100, 15'h1297, 0,  0};
    vecs[4] = '{15'h7FF0, 16'd40,  1, 2, 40,  15'h0017, 0,  0};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("post_reset");

    for (int v = 0; v < 5; v++) begin
      mem_mode = vecs[v].mmode;
      tx_mode  = vecs[v].tmode;
      do_start(vecs[v].base, vecs[v].len, 1'b1);
      wait_done(2000, $sformatf("v%0d_done_seen", v));
      chk($sformatf("v%0d_ndone", v), ndone, 1);
      chk($sformatf("v%0d_nreq", v), nreq, vecs[v].exp_req);
      chk($sformatf("v%0d_nflit", v), nflit, vecs[v].len);
      chk($sformatf("v%0d_nlast", v), nlast, vecs[v].len != 0);
      chk($sformatf("v%0d_left", v),
          exp_addr_q.size() + exp_data_q.size(), 0);
      if (vecs[v].exp_req != 0)
        chk($sformatf("v%0d_last_addr", v),
            last_req_addr, vecs[v].exp_last_addr);
      if (vecs[v].exp_busy != 0) begin
        chk($sformatf("v%0d_busy", v), busy_cnt, vecs[v].exp_busy);
        chk($sformatf("v%0d_done_lat", v),
            done_cyc - start_cyc, vecs[v].exp_done_lat);
      end
      if (vecs[v].exp_busy != 0 && vecs[v].exp_req != 0) begin
        chk($sformatf("v%0d_first_req", v),
            first_req_cyc - start_cyc, 1);
        chk($sformatf("v%0d_req_span", v),
            last_req_cyc - first_req_cyc, vecs[v].exp_req - 1);
      end
    end

    // NoC back-pressure: only FIFO_DEPTH requests may be outstanding
    mem_mode = 0;
    tx_mode  = 1;
    do_start(15'h0200, 16'd16, 1'b1);
    repeat (20) @(negedge clk);
    chk("stall_nreq", nreq, FD);
    chk("stall_cen", mem_cen, 0);
    chk("stall_valid", noc_tx_valid, 1);
    chk("stall_nflit", nflit, 0);
    tx_mode = 0;
    wait_done(200, "stall_done_seen");
    chk("stall_total_flit", nflit, 16);
    chk("stall_nlast", nlast, 1);
    chk("stall_ndone", ndone, 1);
    chk("stall_left", exp_data_q.size(), 0);

    // reset in the middle of a transfer
    mem_mode = 0;
    tx_mode  = 2;
    do_start(15'h0300, 16'd16, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    repeat (2) @(negedge clk);
    chk_zero("rst_hold");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    begin
      bit quiet = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (noc_tx_valid || mem_cen || done || busy || mem_rready)
          quiet = 1'b0;
      end
      chk("rst_quiet", quiet, 1);
    end
    chk("rst_no_done", ndone, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    flush = 1'b1;
    repeat (2) @(posedge clk);
    do_start(15'h0040, 16'd3, 1'b1);
    do_start(15'h0500, 16'd9, 1'b0);
    wait_done(200, "rst_new_done_seen");
    repeat (10) @(negedge clk);
    chk("rst_new_nreq", nreq, 3);
    chk("rst_new_nflit", nflit, 3);
    chk("rst_new_nlast", nlast, 1);
    chk("rst_new_ndone", ndone, 1);
    chk("rst_new_left", exp_addr_q.size() + exp_data_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
